register_file_pipelined: RTL and testbench

Parametrised successor to the 8×16 asynchronous-read register file: a clocked multi-port register file with configurable width, depth and read-port count. Reads are registered with one cycle of latency, and a same-cycle write-to-read bypass is included. Each entry carries a per-register valid bit. It sits between instruction decode and the ALU in the teaching CPU datapath. Enables keep the active-low polarity used by the earlier file.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 57 +++++
 rtl/register_file_pipelined.sv | 65 ++++++
 tb/tb_register_file_pipelined.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the pipelined register file: default geometry,
// reset data value and the address of the optional hard-wired zero register.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_DEPTH    = 8;
    localparam int unsigned DEFAULT_NUM_READ = 2;

    localparam int unsigned RESET_DATA = 0;
    localparam int unsigned ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read slice: zero-register override, write-to-read bypass,
// array lookup, and hold of the previous result while oe is high.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned AW       = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             oe,
    input  logic             we,
    input  logic [AW-1:0]    write_address,
    input  logic [WIDTH-1:0] write,
    input  logic [AW-1:0]    read_address,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_valid,
    output logic [WIDTH-1:0] read,
    output logic             read_valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    // Zero register wins over the bypass; the bypass wins over stored contents.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (!oe) begin
            if (ZERO_REG && (read_address == AW'(ZERO_ADDR))) begin
                data_d  = WIDTH'(RESET_DATA);
                valid_d = 1'b1;
            end else if (!we && (write_address == read_address)) begin
                data_d  = write;
                valid_d = 1'b1;
            end else begin
                data_d  = mem_data;
                valid_d = mem_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= WIDTH'(RESET_DATA);
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign read       = data_q;
    assign read_valid = valid_q;

endmodule

// File: rtl/register_file_pipelined.sv
// Multi-port register file with registered reads, same-cycle write bypass and
// per-entry valid bits. Enables are active-low; reset is synchronous.
module register_file_pipelined
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    localparam int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned NUM_READ = DEFAULT_NUM_READ,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic                      oe,
    input  logic [AW-1:0]             write_address,
    input  logic [WIDTH-1:0]          write,
    input  logic [NUM_READ*AW-1:0]    read_address,
    output logic [NUM_READ*WIDTH-1:0] read,
    output logic [NUM_READ-1:0]       read_valid
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             write_en;

    assign write_en = !we && !(ZERO_REG && (write_address == AW'(ZERO_ADDR)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]   <= WIDTH'(RESET_DATA);
                valid_q[i] <= ZERO_REG && (i == ZERO_ADDR);
            end
        end else if (write_en) begin
            mem_q[write_address]   <= write;
            valid_q[write_address] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : gen_read_port
        logic [AW-1:0] port_address;

        assign port_address = read_address[k*AW +: AW];

        regfile_read_port #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_read_port (
            .clk           (clk),
            .rst_n         (rst_n),
            .oe            (oe),
            .we            (we),
            .write_address (write_address),
            .write         (write),
            .read_address  (port_address),
            .mem_data      (mem_q[port_address]),
            .mem_valid     (valid_q[port_address]),
            .read          (read[k*WIDTH +: WIDTH]),
            .read_valid    (read_valid[k])
        );
    end

endmodule

// File: tb/tb_register_file_pipelined.sv
// Directed bench for three configurations: default, zero-register, and 32x16 with four ports.
module tb_register_file_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default configuration: 16 bits, 8 entries, 2 ports.
    logic        a_rst_n, a_we, a_oe;
    logic [2:0]  a_wa;
    logic [15:0] a_wd;
    logic [5:0]  a_ra;
    logic [31:0] a_rd;
    logic [1:0]  a_rv;

    // Zero-register configuration.
    logic        b_rst_n, b_we, b_oe;
    logic [2:0]  b_wa;
    logic [15:0] b_wd;
    logic [5:0]  b_ra;
    logic [31:0] b_rd;
    logic [1:0]  b_rv;

    // Wide configuration: 32 bits, 16 entries, 4 ports.
    logic         c_rst_n, c_we, c_oe;
    logic [3:0]   c_wa;
    logic [31:0]  c_wd;
    logic [15:0]  c_ra;
    logic [127:0] c_rd;
    logic [3:0]   c_rv;

    register_file_pipelined u_dut_a (
        .clk           (clk),
        .rst_n         (a_rst_n),
        .we            (a_we),
        .oe            (a_oe),
        .write_address (a_wa),
        .write         (a_wd),
        .read_address  (a_ra),
        .read          (a_rd),
        .read_valid    (a_rv)
    );

    register_file_pipelined #(
        .ZERO_REG (1'b1)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (b_rst_n),
        .we            (b_we),
        .oe            (b_oe),
        .write_address (b_wa),
        .write         (b_wd),
        .read_address  (b_ra),
        .read          (b_rd),
        .read_valid    (b_rv)
    );

    register_file_pipelined #(
        .WIDTH    (32),
        .DEPTH    (16),
        .NUM_READ (4)
    ) u_dut_c (
        .clk           (clk),
        .rst_n         (c_rst_n),
        .we            (c_we),
        .oe            (c_oe),
        .write_address (c_wa),
        .write         (c_wd),
        .read_address  (c_ra),
        .read          (c_rd),
        .read_valid    (c_rv)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_we = 1'b1; a_oe = 1'b1; a_wa = '0; a_wd = '0; a_ra = '0;
        b_rst_n = 1'b0; b_we = 1'b1; b_oe = 1'b1; b_wa = '0; b_wd = '0; b_ra = '0;
        c_rst_n = 1'b0; c_we = 1'b1; c_oe = 1'b1; c_wa = '0; c_wd = '0; c_ra = '0;
        tick();
        tick();
        check_eq("a_reset_read", a_rd, 0);
        check_eq("a_reset_valid", a_rv, 0);
        check_eq("b_reset_valid", b_rv, 0);
        check_eq("c_reset_read", c_rd, 0);

        // Default configuration.
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        a_we = 1'b0; a_wa = 3'd3; a_wd = 16'hf000; a_oe = 1'b1;
        tick();
        check_eq("a_oe_high_no_read", a_rd, 0);

        a_we = 1'b1; a_oe = 1'b0; a_ra = {3'd5, 3'd3};
        tick();
        check_eq("a_read0_r3", a_rd[15:0], 16'hf000);
        check_eq("a_valid0_r3", a_rv[0], 1'b1);
        check_eq("a_read1_r5", a_rd[31:16], 16'h0000);
        check_eq("a_valid1_r5", a_rv[1], 1'b0);

        a_we = 1'b0; a_wa = 3'd5; a_wd = 16'h0f00; a_ra = {3'd5, 3'd3};
        tick();
        check_eq("a_bypass_read1", a_rd[31:16], 16'h0f00);
        check_eq("a_bypass_valid1", a_rv[1], 1'b1);
        check_eq("a_bypass_read0", a_rd[15:0], 16'hf000);

        a_oe = 1'b1; a_we = 1'b0; a_wa = 3'd3; a_wd = 16'h1234;
        tick();
        check_eq("a_hold_read", a_rd, 32'h0f00_f000);
        check_eq("a_hold_valid", a_rv, 2'b11);

        a_oe = 1'b0; a_we = 1'b1;
        tick();
        check_eq("a_after_hold_read0", a_rd[15:0], 16'h1234);

        a_ra = {3'd5, 3'd5};
        tick();
        check_eq("a_same_addr_read", a_rd, 32'h0f00_0f00);

        a_we = 1'b0; a_wa = 3'd0; a_wd = 16'h5555; a_ra = {3'd7, 3'd0};
        tick();
        check_eq("a_r0_normal_read", a_rd, 32'h0000_5555);
        check_eq("a_r0_normal_valid", a_rv, 2'b01);

        // Reset beats a simultaneous write and bypass read.
        a_we = 1'b0; a_wa = 3'd3; a_wd = 16'habcd; a_oe = 1'b0; a_ra = {3'd0, 3'd3};
        a_rst_n = 1'b0;
        tick();
        check_eq("a_rst_override_read", a_rd, 0);
        check_eq("a_rst_override_valid", a_rv, 0);

        a_rst_n = 1'b1; a_we = 1'b1;
        tick();
        check_eq("a_post_reset_read", a_rd, 0);
        check_eq("a_post_reset_valid", a_rv, 0);

        // Zero-register configuration.
        b_we = 1'b1; b_oe = 1'b0; b_ra = {3'd0, 3'd0};
        tick();
        check_eq("b_r0_read", b_rd, 0);
        check_eq("b_r0_valid", b_rv, 2'b11);

        b_we = 1'b0; b_wa = 3'd0; b_wd = 16'hffff;
        tick();
        check_eq("b_r0_write_same_edge", b_rd, 0);
        check_eq("b_r0_valid_same_edge", b_rv, 2'b11);

        b_we = 1'b1;
        tick();
        check_eq("b_r0_write_next_edge", b_rd, 0);
        check_eq("b_r0_valid_next_edge", b_rv, 2'b11);

        b_we = 1'b0; b_wa = 3'd1; b_wd = 16'hffff; b_ra = {3'd0, 3'd1};
        tick();
        check_eq("b_r1_bypass_read", b_rd, 32'h0000_ffff);
        check_eq("b_r1_bypass_valid", b_rv, 2'b11);

        // Wide configuration.
        c_we = 1'b0; c_wa = 4'd15; c_wd = 32'hdeadbeef; c_oe = 1'b1;
        tick();
        c_we = 1'b1; c_oe = 1'b0; c_ra = {4'd15, 4'd15, 4'd15, 4'd15};
        tick();
        check_eq("c_all_ports_read", c_rd, {4{32'hdeadbeef}});
        check_eq("c_all_ports_valid", c_rv, 4'b1111);

        c_ra = {4'd15, 4'd14, 4'd0, 4'd15};
        tick();
        check_eq("c_mixed_read", c_rd, {32'hdeadbeef, 32'h0, 32'h0, 32'hdeadbeef});
        check_eq("c_mixed_valid", c_rv, 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
